// File: rtl/tau_pkg.sv
// Shared types for the fetch/execute front end: memory-controller op codes,
// fetch sequencer states and a small op-classification helper.
package tau_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    LOAD   = 3'd1,
    STORE  = 3'd2,
    LOADV  = 3'd3,
    STOREV = 3'd4,
    PEEK   = 3'd5
  } load_store_op_set;

  typedef enum logic [2:0] {
    SEQ_FETCH,
    SEQ_FETCH_DATA,
    SEQ_PEEK,
    SEQ_PEEK_DATA,
    SEQ_HOLD,
    SEQ_MEM,
    SEQ_MEM_DATA
  } seq_state_t;

  // Only LOAD..STOREV may reach the memory controller from the data port.
  function automatic logic is_data_op(input logic [2:0] op);
    return (op >= 3'd1) && (op <= 3'd4);
  endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Program-counter owner and instruction fetch front end for memory_controller.
// Fetches one/two-word instructions and interleaves execute-stage data requests.
module fetch_sequencer
  import tau_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_WIDTH-1:0]    p_ram_rdata,
  input  logic [DATA_WIDTH-1:0]    v_ram_rdata,
  output logic [ADDRESS_WIDTH-1:0] program_counter_address,
  output logic [2:0]               microcode_control,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [DATA_WIDTH-1:0]    instr_word,
  output logic [DATA_WIDTH-1:0]    instr_operand,
  input  logic                     jump_valid,
  input  logic [ADDRESS_WIDTH-1:0] jump_target,
  input  logic                     mem_req_valid,
  input  logic [2:0]               mem_req_op,
  input  logic [ADDRESS_WIDTH-1:0] mem_req_addr,
  input  logic [DATA_WIDTH-1:0]    mem_req_wdata,
  output logic                     mem_req_ready,
  output logic                     mem_rsp_valid,
  output logic [DATA_WIDTH-1:0]    mem_rsp_data
);

  seq_state_t               state_q;
  load_store_op_set         mc_q;
  logic [2:0]               op_q;
  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
  logic [ADDRESS_WIDTH-1:0] mem_address_q;
  logic [DATA_WIDTH-1:0]    mem_wdata_q;
  logic [DATA_WIDTH-1:0]    instr_word_q, instr_operand_q;
  logic                     rsp_valid_q;
  logic [DATA_WIDTH-1:0]    rsp_data_q;

  // Wraps modulo 2^ADDRESS_WIDTH, including PC+2 from all-ones-minus-one.
  function automatic logic [ADDRESS_WIDTH-1:0] next_pc(
    input logic [ADDRESS_WIDTH-1:0] pc,
    input logic                     two_word,
    input logic                     jv,
    input logic [ADDRESS_WIDTH-1:0] jt
  );
    if (jv) return jt;
    return pc + (two_word ? ADDRESS_WIDTH'(2) : ADDRESS_WIDTH'(1));
  endfunction

  assign pc_d = next_pc(pc_q, instr_word_q[DATA_WIDTH-1], jump_valid, jump_target);

  // A pending data request pre-empts the instruction handshake in HOLD.
  assign instr_valid   = (state_q == SEQ_HOLD) && !mem_req_valid;
  assign mem_req_ready = (state_q == SEQ_HOLD) && mem_req_valid;

  assign program_counter_address = pc_q;
  assign microcode_control       = mc_q;
  assign mem_address             = mem_address_q;
  assign mem_wdata               = mem_wdata_q;
  assign instr_word              = instr_word_q;
  assign instr_operand           = instr_operand_q;
  assign mem_rsp_valid           = rsp_valid_q;
  assign mem_rsp_data            = rsp_data_q;

  // NOTE: every register here uses non-blocking assignment so each branch
  // sees the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= SEQ_FETCH;
      mc_q            <= FETCH;
      op_q            <= 3'd0;
      pc_q            <= '0;
      mem_address_q   <= '0;
      mem_wdata_q     <= '0;
      instr_word_q    <= '0;
      instr_operand_q <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_data_q      <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        SEQ_FETCH: begin
          mc_q    <= FETCH;
          state_q <= SEQ_FETCH_DATA;
        end
        SEQ_FETCH_DATA: begin
          instr_word_q <= p_ram_rdata;
          if (p_ram_rdata[DATA_WIDTH-1]) begin
            mc_q    <= PEEK;
            state_q <= SEQ_PEEK;
          end else begin
            instr_operand_q <= '0;
            mc_q            <= FETCH;
            state_q         <= SEQ_HOLD;
          end
        end
        SEQ_PEEK: begin
          state_q <= SEQ_PEEK_DATA;
        end
        SEQ_PEEK_DATA: begin
          instr_operand_q <= p_ram_rdata;
          mc_q            <= FETCH;
          state_q         <= SEQ_HOLD;
        end
        SEQ_HOLD: begin
          if (mem_req_valid) begin
            op_q          <= mem_req_op;
            mem_address_q <= mem_req_addr;
            mem_wdata_q   <= mem_req_wdata;
            mc_q          <= is_data_op(mem_req_op) ? load_store_op_set'(mem_req_op) : FETCH;
            state_q       <= SEQ_MEM;
          end else if (instr_ready) begin
            pc_q    <= pc_d;
            state_q <= SEQ_FETCH;
          end
        end
        SEQ_MEM: begin
          if (op_q == LOAD || op_q == LOADV) begin
            state_q <= SEQ_MEM_DATA;
          end else begin
            rsp_valid_q <= 1'b1;
            mc_q        <= FETCH;
            state_q     <= SEQ_HOLD;
          end
        end
        SEQ_MEM_DATA: begin
          rsp_data_q  <= (op_q == LOADV) ? v_ram_rdata : p_ram_rdata;
          rsp_valid_q <= 1'b1;
          mc_q        <= FETCH;
          state_q     <= SEQ_HOLD;
        end
        default: begin
          mc_q    <= FETCH;
          state_q <= SEQ_FETCH;
        end
      endcase
    end
  end

endmodule
